// File: rtl/axi_llc_sram_port.sv
// Request/response adapter in front of an LLC SRAM macro wrapper.
// Converts a valid/ready request channel into the macro req/gnt/we interface,
// tracks reads across the fixed macro latency and buffers read data in a small
// response FIFO. Reads are only issued while a FIFO slot is guaranteed, so the
// consumer may stall indefinitely without losing data.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake (ready is combinational)
//   req_we_i, req_addr_i, req_wdata_i, req_be_i   request payload
//   rsp_valid_o / rsp_ready_i  read response handshake (registered output)
//   rsp_rdata_o                read data
//   sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o  macro request
//   sram_gnt_i                 macro grant
//   sram_rdata_i               macro read data, Latency cycles after the read
module axi_llc_sram_port #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 2,
  // Derived; do not override.
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic                 sram_gnt_i,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntWidth = $clog2(RspDepth + 1);
  localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  logic [Latency-1:0]   inflight_q;
  logic [CntWidth-1:0]  inflight_cnt_q, inflight_cnt_d;
  logic [CntWidth-1:0]  fifo_cnt_q, fifo_cnt_d, cnt_after_pop;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] mem_q [RspDepth];
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CntWidth:0]    outstanding;
  logic                 credit_ok, read_issue, push, pop;

  function automatic logic [PtrWidth-1:0] inc_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // Credit: every outstanding read owns one FIFO slot; pops return credit a cycle late.
  assign outstanding = (CntWidth+1)'(inflight_cnt_q) + (CntWidth+1)'(fifo_cnt_q);
  assign credit_ok   = req_we_i | (outstanding < (CntWidth+1)'(RspDepth));

  // Request path straight through to the macro.
  assign sram_req_o   = req_valid_i & credit_ok;
  assign req_ready_o  = sram_gnt_i & credit_ok;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign read_issue = req_valid_i & req_ready_o & ~req_we_i;
  assign push       = inflight_q[Latency-1];
  assign pop        = rsp_valid_q & rsp_ready_i;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

  // Next-state for counters, pointers and the registered FIFO head.
  always_comb begin
    cnt_after_pop  = fifo_cnt_q - CntWidth'(pop);
    fifo_cnt_d     = cnt_after_pop + CntWidth'(push);
    inflight_cnt_d = inflight_cnt_q + CntWidth'(read_issue) - CntWidth'(push);
    rd_ptr_d       = pop  ? inc_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d       = push ? inc_ptr(wr_ptr_q) : wr_ptr_q;
    rsp_valid_d    = (fifo_cnt_d != '0);
    rsp_rdata_d    = rsp_rdata_q;
    // New head is either already stored, or is the word arriving this edge.
    if (cnt_after_pop != '0) begin
      rsp_rdata_d = mem_q[rd_ptr_d];
    end else if (push) begin
      rsp_rdata_d = sram_rdata_i;
    end
  end

  // Control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q     <= '0;
      inflight_cnt_q <= '0;
      fifo_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      inflight_q[0] <= read_issue;
      for (int unsigned i = 1; i < Latency; i++) begin
        inflight_q[i] <= inflight_q[i-1];
      end
      inflight_cnt_q <= inflight_cnt_d;
      fifo_cnt_q     <= fifo_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  // FIFO storage; contents are don't-care until the count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sram_rdata_i;
    end
  end

endmodule

// File: tb/tb_axi_llc_sram_port.sv
// Self-checking bench for axi_llc_sram_port. Two instances: u1 (Latency=1,
// RspDepth=2) and u2 (Latency=2, RspDepth=3), each with its own SRAM model.
// Expected read data comes from a shadow memory updated on write handshakes
// and is queued per read handshake, then compared when the response pops.
module tb_axi_llc_sram_port;

  logic        clk = 1'b0;
  logic        rst1, rst2;
  logic        req_valid1, req_valid2, req_ready1, req_ready2;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid1, rsp_valid2, rsp_ready1, rsp_ready2;
  logic [31:0] rsp_rdata1, rsp_rdata2;
  logic        sram_req1, sram_we1, sram_req2, sram_we2;
  logic [3:0]  sram_addr1, sram_addr2, sram_be1, sram_be2;
  logic [31:0] sram_wdata1, sram_wdata2, sram_rdata1, sram_rdata2, stage2;
  logic        gnt;

  logic [31:0] mem1 [16];
  logic [31:0] mem2 [16];
  logic [31:0] sh1 [16];
  logic [31:0] sh2 [16];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  int          tq1 [$];
  int          tq2 [$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        lat_chk = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_llc_sram_port #(.NumWords(16), .DataWidth(32), .ByteWidth(8), .Latency(1), .RspDepth(2)) u1 (
    .clk_i(clk), .rst_ni(rst1), .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_rdata_o(rsp_rdata1),
    .sram_req_o(sram_req1), .sram_we_o(sram_we1), .sram_addr_o(sram_addr1),
    .sram_wdata_o(sram_wdata1), .sram_be_o(sram_be1), .sram_gnt_i(gnt), .sram_rdata_i(sram_rdata1));

  axi_llc_sram_port #(.NumWords(16), .DataWidth(32), .ByteWidth(8), .Latency(2), .RspDepth(3)) u2 (
    .clk_i(clk), .rst_ni(rst2), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_rdata_o(rsp_rdata2),
    .sram_req_o(sram_req2), .sram_we_o(sram_we2), .sram_addr_o(sram_addr2),
    .sram_wdata_o(sram_wdata2), .sram_be_o(sram_be2), .sram_gnt_i(gnt), .sram_rdata_i(sram_rdata2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // SRAM macro models: 1-cycle and 2-cycle read latency.
  always @(posedge clk) begin
    if (sram_req1 && gnt) begin
      if (sram_we1) mem1[sram_addr1] <= apply_be(mem1[sram_addr1], sram_wdata1, sram_be1);
      else          sram_rdata1 <= mem1[sram_addr1];
    end
    if (sram_req2 && gnt) begin
      if (sram_we2) mem2[sram_addr2] <= apply_be(mem2[sram_addr2], sram_wdata2, sram_be2);
      else          stage2 <= mem2[sram_addr2];
    end
    sram_rdata2 <= stage2;
  end

  // Scoreboard for u1: compare on pop, push expectations on read handshake.
  always @(negedge clk) begin
    if (!rst1) begin
      q1.delete(); tq1.delete();
    end else begin
      if (rsp_valid1 && rsp_ready1) begin
        if (q1.size() == 0) check("u1_spurious_rsp", 1, 0);
        else begin
          int t;
          logic [31:0] e;
          e = q1.pop_front(); t = tq1.pop_front();
          check("u1_rdata", rsp_rdata1, e);
          if (lat_chk) check("u1_latency", 64'(cyc - t), 2);
        end
      end else if (q1.size() == 0) check("u1_idle_valid", rsp_valid1, 0);
      if (u1.push) check("u1_no_overflow", (u1.fifo_cnt_q < 2) || u1.pop, 1);
      if (req_valid1 && req_ready1) begin
        if (req_we) sh1[req_addr] = apply_be(sh1[req_addr], req_wdata, req_be);
        else begin q1.push_back(sh1[req_addr]); tq1.push_back(cyc); end
      end
    end
  end

  // Scoreboard for u2.
  always @(negedge clk) begin
    if (!rst2) begin
      q2.delete(); tq2.delete();
    end else begin
      if (rsp_valid2 && rsp_ready2) begin
        if (q2.size() == 0) check("u2_spurious_rsp", 1, 0);
        else begin
          int t;
          logic [31:0] e;
          e = q2.pop_front(); t = tq2.pop_front();
          check("u2_rdata", rsp_rdata2, e);
          if (lat_chk) check("u2_latency", 64'(cyc - t), 3);
        end
      end else if (q2.size() == 0) check("u2_idle_valid", rsp_valid2, 0);
      if (u2.push) check("u2_no_overflow", (u2.fifo_cnt_q < 3) || u2.pop, 1);
      if (req_valid2 && req_ready2) begin
        if (req_we) sh2[req_addr] = apply_be(sh2[req_addr], req_wdata, req_be);
        else begin q2.push_back(sh2[req_addr]); tq2.push_back(cyc); end
      end
    end
  end

  // Drive one request (called at posedge+1), hold until accepted, return at posedge+1.
  task automatic do_req(input int inst, input logic we, input logic [3:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    int n;
    n = 0;
    req_we = we; req_addr = addr; req_wdata = data; req_be = be;
    if (inst == 1) req_valid1 = 1'b1; else req_valid2 = 1'b1;
    #1;
    while (((inst == 1) ? !req_ready1 : !req_ready2) && n < 50) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 50) check("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_valid2 = 1'b0;
  endtask

  task automatic wait_drain(input int inst);
    int n;
    n = 0;
    while (((inst == 1) ? q1.size() : q2.size()) != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    check("drain", (inst == 1) ? q1.size() : q2.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = '0; mem2[i] = '0; sh1[i] = '0; sh2[i] = '0;
    end
    sram_rdata1 = '0; sram_rdata2 = '0; stage2 = '0;
    rst1 = 1'b0; rst2 = 1'b0; req_valid1 = 1'b0; req_valid2 = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready1 = 1'b1; rsp_ready2 = 1'b1; gnt = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid1, 0);
    check("rst_rsp_rdata", rsp_rdata1, 0);
    check("rst_sram_req", sram_req1, 0);
    check("rst_req_ready", req_ready1, 1);
    rst1 = 1'b1; rst2 = 1'b1;
    @(posedge clk); #1;

    // Write 0xA5 then read it back: one response, two cycles after the read.
    do_req(1, 1'b1, 4'd3, 32'hA5, 4'hF);
    do_req(1, 1'b0, 4'd3, 32'h0, 4'hF);
    wait_drain(1);

    // Reads of 0..7. The pop frees credit only a cycle later, so with two
    // credits and a two-cycle read-to-pop loop the port takes 2 reads per 3 cycles.
    for (int i = 0; i < 8; i++) do_req(1, 1'b1, 4'(i), 32'h1000_0000 + 32'(i) * 32'h0101, 4'hF);
    t0 = cyc;
    for (int i = 0; i < 8; i++) do_req(1, 1'b0, 4'(i), 32'h0, 4'hF);
    check("b2b_elapsed", 64'(cyc - t0), 11);
    wait_drain(1);

    // Consumer stalled: two reads fill the credits.
    lat_chk = 1'b0;
    rsp_ready1 = 1'b0;
    do_req(1, 1'b0, 4'd0, 32'h0, 4'hF);
    do_req(1, 1'b0, 4'd1, 32'h0, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    // Writes still flow one per cycle while reads are blocked.
    t0 = cyc;
    do_req(1, 1'b1, 4'd8,  32'h8888_8888, 4'hF);
    do_req(1, 1'b1, 4'd9,  32'h9999_9999, 4'hF);
    do_req(1, 1'b1, 4'd10, 32'hDEAD_BEEF, 4'hF);
    check("full_write_elapsed", 64'(cyc - t0), 3);
    req_we = 1'b0; req_addr = 4'd2; req_be = 4'hF; req_valid1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; check("full_read_stall", req_ready1, 0);
      @(posedge clk); #1;
    end
    // First pop this cycle; credit returns next cycle.
    rsp_ready1 = 1'b1;
    #1; check("pop_cycle_ready", req_ready1, 0);
    @(posedge clk); #2;
    check("after_pop_ready", req_ready1, 1);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    do_req(1, 1'b0, 4'd3, 32'h0, 4'hF);
    wait_drain(1);
    lat_chk = 1'b1;

    // Partial byte-enable write, read back.
    do_req(1, 1'b1, 4'd10, 32'h1234_5678, 4'b0011);
    do_req(1, 1'b0, 4'd10, 32'h0, 4'hF);
    do_req(1, 1'b0, 4'd9,  32'h0, 4'hF);
    wait_drain(1);

    // Grant low for three cycles: no issue, no tracker bit.
    gnt = 1'b0;
    req_we = 1'b0; req_addr = 4'd5; req_be = 4'hF; req_valid1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nognt_ready", req_ready1, 0);
      check("nognt_sram_req", sram_req1, 1);
      check("nognt_tracker", u1.inflight_q, 0);
      @(posedge clk); #1;
    end
    check("nognt_tracker_end", u1.inflight_q, 0);
    gnt = 1'b1;
    #1; check("gnt_ready", req_ready1, 1);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    wait_drain(1);

    // Latency=2, RspDepth=3: reset with 2 reads in flight and 1 buffered.
    do_req(2, 1'b1, 4'd1, 32'hAAAA_0001, 4'hF);
    do_req(2, 1'b1, 4'd2, 32'hAAAA_0002, 4'hF);
    do_req(2, 1'b1, 4'd3, 32'hAAAA_0003, 4'hF);
    do_req(2, 1'b1, 4'd4, 32'hBBBB_0004, 4'hF);
    rsp_ready2 = 1'b0;
    do_req(2, 1'b0, 4'd1, 32'h0, 4'hF);
    do_req(2, 1'b0, 4'd2, 32'h0, 4'hF);
    do_req(2, 1'b0, 4'd3, 32'h0, 4'hF);
    check("u2_buffered_valid", rsp_valid2, 1);
    check("u2_buffered_data", rsp_rdata2, 32'hAAAA_0001);
    rst2 = 1'b0;
    #1;
    check("u2_rst_valid", rsp_valid2, 0);
    check("u2_rst_rdata", rsp_rdata2, 0);
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b1;
    rsp_ready2 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("u2_post_rst_rdata", rsp_rdata2, 0);
    do_req(2, 1'b0, 4'd4, 32'h0, 4'hF);
    wait_drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
